fixed_point_multiplier_pipe: RTL and testbench

Pipelined, parametrised signed fixed-point multiplier with a valid/ready stream handshake, selectable rounding and saturating or wrapping overflow handling. It is the clocked successor to the asynchronous multiplier, and the multiply primitive for the FIR tap datapath. It accepts one operand pair per cycle and returns the product re-quantised to the C format after exactly PIPE_STAGES cycles when unstalled.

---
 rtl/fixed_point_multiplier_pipe.sv | 125 ++++++++++++
 tb/tb_fixed_point_multiplier_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_multiplier_pipe.sv
// Pipelined signed fixed-point multiplier with a valid/ready stream interface.
// The product is formed exactly, re-quantised to the C format (truncate or
// round half up), then clamped or wrapped into C_WORD_LEN bits. The result
// then walks through a delay line so that total latency equals PIPE_STAGES.
module fixed_point_multiplier_pipe #(
    parameter int A_FRAC_LEN  = 2,
    parameter int A_WORD_LEN  = 4,
    parameter int B_FRAC_LEN  = 3,
    parameter int B_WORD_LEN  = 7,
    parameter int C_FRAC_LEN  = 2,
    parameter int C_WORD_LEN  = 7,
    parameter int PIPE_STAGES = 2,
    parameter int ROUND_MODE  = 0,
    parameter int SATURATE    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [A_WORD_LEN-1:0] a,
    input  logic signed [B_WORD_LEN-1:0] b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [C_WORD_LEN-1:0] c,
    output logic                         ovf
);

    // Full product width and the shift that drops the surplus fraction bits.
    localparam int PW    = A_WORD_LEN + B_WORD_LEN;
    localparam int SH    = A_FRAC_LEN + B_FRAC_LEN - C_FRAC_LEN;
    localparam int SH_M1 = (SH > 0) ? SH - 1 : 0;
    // Working width: one bit above the product for the rounding add, and wide
    // enough to hold the C range limits with a spare sign bit.
    localparam int QW    = ((PW + 1 > C_WORD_LEN) ? PW + 1 : C_WORD_LEN) + 1;

    localparam logic signed [QW-1:0] ONE      = 1;
    localparam logic signed [QW-1:0] RND_BIAS =
        ((ROUND_MODE == 1) && (SH > 0)) ? (ONE <<< SH_M1) : '0;
    localparam logic signed [QW-1:0] CMAX =
        {{(QW-C_WORD_LEN+1){1'b0}}, {(C_WORD_LEN-1){1'b1}}};
    localparam logic signed [QW-1:0] CMIN =
        {{(QW-C_WORD_LEN+1){1'b1}}, {(C_WORD_LEN-1){1'b0}}};

    generate
        if (C_FRAC_LEN > A_FRAC_LEN + B_FRAC_LEN) begin : g_bad_frac
            $error("C_FRAC_LEN must not exceed A_FRAC_LEN + B_FRAC_LEN");
        end
        if (PIPE_STAGES < 1) begin : g_bad_stages
            $error("PIPE_STAGES must be at least 1");
        end
    endgenerate

    // Sign-extend the product into the working width, add the rounding bias
    // (zero when truncating) and shift arithmetically, which floors.
    function automatic logic signed [QW-1:0] requant(input logic signed [PW-1:0] p);
        logic signed [QW-1:0] p_ext;
        p_ext = {{(QW-PW){p[PW-1]}}, p};
        p_ext = p_ext + RND_BIAS;
        return p_ext >>> SH;
    endfunction

    // Returns {ovf, c}. Out-of-range values clamp to the nearest limit or keep
    // their low bits; the overflow flag is raised either way.
    function automatic logic [C_WORD_LEN:0] clamp(input logic signed [QW-1:0] q);
        logic [C_WORD_LEN:0] r;
        if (q > CMAX) begin
            r = (SATURATE != 0) ? {1'b1, CMAX[C_WORD_LEN-1:0]} : {1'b1, q[C_WORD_LEN-1:0]};
        end else if (q < CMIN) begin
            r = (SATURATE != 0) ? {1'b1, CMIN[C_WORD_LEN-1:0]} : {1'b1, q[C_WORD_LEN-1:0]};
        end else begin
            r = {1'b0, q[C_WORD_LEN-1:0]};
        end
        return r;
    endfunction

    logic signed [PW-1:0]         a_ext;
    logic signed [PW-1:0]         b_ext;
    logic signed [PW-1:0]         prod_d;
    logic signed [QW-1:0]         quant_d;
    logic        [C_WORD_LEN:0]   res_d;

    logic        [PIPE_STAGES-1:0] vld_q;
    logic        [PIPE_STAGES-1:0] ovf_q;
    logic signed [C_WORD_LEN-1:0]  c_q [PIPE_STAGES];

    logic stall;

    // The whole pipe freezes only when the last stage holds an unaccepted result.
    assign stall    = vld_q[PIPE_STAGES-1] & ~out_ready;
    assign in_ready = ~stall;

    assign out_valid = vld_q[PIPE_STAGES-1];
    assign c         = c_q[PIPE_STAGES-1];
    assign ovf       = ovf_q[PIPE_STAGES-1];

    // Exact product of the sign-extended operands, then re-quantise and range-limit.
    always_comb begin
        a_ext   = {{B_WORD_LEN{a[A_WORD_LEN-1]}}, a};
        b_ext   = {{A_WORD_LEN{b[B_WORD_LEN-1]}}, b};
        prod_d  = a_ext * b_ext;
        quant_d = requant(prod_d);
        res_d   = clamp(quant_d);
    end

    // Stage 0 captures the finished result; later stages form the latency delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            ovf_q <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                c_q[i] <= '0;
            end
        end else if (!stall) begin
            vld_q[0] <= in_valid;
            ovf_q[0] <= res_d[C_WORD_LEN];
            c_q[0]   <= res_d[C_WORD_LEN-1:0];
            for (int i = 1; i < PIPE_STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                ovf_q[i] <= ovf_q[i-1];
                c_q[i]   <= c_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_multiplier_pipe.sv
// Bench for fixed_point_multiplier_pipe: four instances covering
// truncate/round, saturate/wrap and latencies 1, 2 and 4 share one stimulus.
module tb_fixed_point_multiplier_pipe;

    localparam int CW = 7;
    localparam int SH = 3;
    localparam int PSTG [4] = '{2, 2, 1, 4};
    localparam int RMOD [4] = '{0, 1, 0, 1};
    localparam int SATM [4] = '{1, 1, 0, 0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] a;
    logic [6:0] b;
    logic       ir [4];
    logic       ov [4];
    logic       of [4];
    logic [6:0] cc [4];

    int  n_checks = 0;
    int  n_err    = 0;
    bit  sb_en    = 1'b0;

    logic [7:0] fifo [4][64];
    int         wp [4];
    int         rp [4];
    bit         prev_stall [4];
    logic [6:0] prev_c [4];
    logic       prev_o [4];

    typedef struct packed {
        logic [3:0]      a;
        logic [6:0]      b;
        logic [3:0][6:0] c;
        logic            ovf;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    fixed_point_multiplier_pipe #(.A_FRAC_LEN(2), .A_WORD_LEN(4), .B_FRAC_LEN(3), .B_WORD_LEN(7),
        .C_FRAC_LEN(2), .C_WORD_LEN(7), .PIPE_STAGES(2), .ROUND_MODE(0), .SATURATE(1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
        .out_valid(ov[0]), .out_ready(out_ready), .c(cc[0]), .ovf(of[0]));

    fixed_point_multiplier_pipe #(.A_FRAC_LEN(2), .A_WORD_LEN(4), .B_FRAC_LEN(3), .B_WORD_LEN(7),
        .C_FRAC_LEN(2), .C_WORD_LEN(7), .PIPE_STAGES(2), .ROUND_MODE(1), .SATURATE(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
        .out_valid(ov[1]), .out_ready(out_ready), .c(cc[1]), .ovf(of[1]));

    fixed_point_multiplier_pipe #(.A_FRAC_LEN(2), .A_WORD_LEN(4), .B_FRAC_LEN(3), .B_WORD_LEN(7),
        .C_FRAC_LEN(2), .C_WORD_LEN(7), .PIPE_STAGES(1), .ROUND_MODE(0), .SATURATE(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
        .out_valid(ov[2]), .out_ready(out_ready), .c(cc[2]), .ovf(of[2]));

    fixed_point_multiplier_pipe #(.A_FRAC_LEN(2), .A_WORD_LEN(4), .B_FRAC_LEN(3), .B_WORD_LEN(7),
        .C_FRAC_LEN(2), .C_WORD_LEN(7), .PIPE_STAGES(4), .ROUND_MODE(1), .SATURATE(0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b),
        .out_valid(ov[3]), .out_ready(out_ready), .c(cc[3]), .ovf(of[3]));

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference: real-number product scaled to C, floored (after +half when
    // rounding), then clamped or wrapped modulo 2^CW. Returns {ovf, c}.
    function automatic logic [7:0] model(input logic [3:0] ar, input logic [6:0] br,
                                         input int rnd, input int sat);
        int p, d, q, cmax, cmin, span, cv;
        bit o;
        p = int'($signed(ar)) * int'($signed(br));
        d = 1 << SH;
        if (rnd != 0) p = p + d / 2;
        q = p / d;
        if ((p % d != 0) && (p < 0)) q = q - 1;
        cmax = (1 << (CW - 1)) - 1;
        cmin = -(1 << (CW - 1));
        span = 1 << CW;
        if (q > cmax || q < cmin) begin
            o = 1'b1;
            if (sat != 0) cv = (q > cmax) ? cmax : cmin;
            else          cv = ((q - cmin) % span + span) % span + cmin;
        end else begin
            o  = 1'b0;
            cv = q;
        end
        return {o, cv[6:0]};
    endfunction

    function automatic vec_t mk(input logic [3:0] av, input logic [6:0] bv,
                                input logic [6:0] c0, input logic [6:0] c1,
                                input logic [6:0] c2, input logic [6:0] c3, input logic o);
        vec_t v;
        v.a = av; v.b = bv; v.ovf = o;
        v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
        return v;
    endfunction

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int k = 0; k < 4; k++) if (wp[k] != rp[k]) e = 1'b0;
        return e;
    endfunction

    // Scoreboard: samples at the falling edge what the next rising edge will transfer.
    task automatic monitor();
        logic [7:0] exp_v;
        bit         st;
        forever begin
            @(negedge clk);
            if (sb_en && rst_n) begin
                for (int k = 0; k < 4; k++) begin
                    st = ov[k] && !out_ready;
                    chk(ir[k] === !st, $sformatf("in_ready d%0d", k), int'(ir[k]), int'(!st));
                    if (prev_stall[k]) begin
                        chk(ov[k] === 1'b1 && cc[k] === prev_c[k] && of[k] === prev_o[k],
                            $sformatf("stall_hold d%0d", k), int'({of[k], cc[k]}),
                            int'({prev_o[k], prev_c[k]}));
                    end
                    if (ov[k] && out_ready) begin
                        if (wp[k] == rp[k]) begin
                            chk(1'b0, $sformatf("unexpected_out d%0d", k), int'({of[k], cc[k]}), -1);
                        end else begin
                            exp_v = fifo[k][rp[k] % 64];
                            rp[k]++;
                            chk({of[k], cc[k]} === exp_v, $sformatf("rand_out d%0d", k),
                                int'({of[k], cc[k]}), int'(exp_v));
                        end
                    end
                    if (in_valid && ir[k]) begin
                        fifo[k][wp[k] % 64] = model(a, b, RMOD[k], SATM[k]);
                        wp[k]++;
                    end
                    prev_stall[k] = st;
                    prev_c[k]     = cc[k];
                    prev_o[k]     = of[k];
                end
            end else begin
                for (int k = 0; k < 4; k++) prev_stall[k] = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        for (int k = 0; k < 4; k++) begin
            wp[k] = 0; rp[k] = 0; prev_stall[k] = 1'b0; prev_c[k] = '0; prev_o[k] = 1'b0;
        end
        // columns: trunc+sat, round+sat, trunc+wrap, round+wrap
        tbl[0] = mk(4'b0110, 7'b0010100, 7'd15,  7'd15,  7'd15,  7'd15,  1'b0);
        tbl[1] = mk(4'b0001, 7'b0000101, 7'd0,   7'd1,   7'd0,   7'd1,   1'b0);
        tbl[2] = mk(4'b1111, 7'b0000101, 7'h7F,  7'h7F,  7'h7F,  7'h7F,  1'b0);
        tbl[3] = mk(4'b1000, 7'b1000000, 7'h3F,  7'h3F,  7'h40,  7'h40,  1'b1);
        tbl[4] = mk(4'b0111, 7'b0111111, 7'd55,  7'd55,  7'd55,  7'd55,  1'b0);
        tbl[5] = mk(4'b1000, 7'b0111111, 7'h41,  7'h41,  7'h41,  7'h41,  1'b0);
        tbl[6] = mk(4'b0001, 7'b0000100, 7'd0,   7'd1,   7'd0,   7'd1,   1'b0);
        tbl[7] = mk(4'b1111, 7'b0000100, 7'h7F,  7'd0,   7'h7F,  7'd0,   1'b0);
        tbl[8] = mk(4'b0000, 7'b1000000, 7'd0,   7'd0,   7'd0,   7'd0,   1'b0);

        fork
            monitor();
        join_none

        #1;
        for (int k = 0; k < 4; k++) begin
            chk(ov[k] === 1'b0, $sformatf("reset out_valid d%0d", k), int'(ov[k]), 0);
            chk(cc[k] === 7'd0, $sformatf("reset c d%0d", k), int'(cc[k]), 0);
            chk(of[k] === 1'b0, $sformatf("reset ovf d%0d", k), int'(of[k]), 0);
            chk(ir[k] === 1'b1, $sformatf("reset in_ready d%0d", k), int'(ir[k]), 1);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, one at a time, checking exact latency per instance.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a = tbl[i].a; b = tbl[i].b; in_valid = 1'b1;
            for (int cyc = 1; cyc <= 5; cyc++) begin
                @(negedge clk);
                if (cyc == 1) in_valid = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    chk(ov[k] === (cyc == PSTG[k]), $sformatf("lat_vld d%0d v%0d c%0d", k, i, cyc),
                        int'(ov[k]), int'(cyc == PSTG[k]));
                    if (cyc == PSTG[k]) begin
                        chk(cc[k] === tbl[i].c[k], $sformatf("vec_c d%0d v%0d", k, i),
                            int'(cc[k]), int'(tbl[i].c[k]));
                        chk(of[k] === tbl[i].ovf, $sformatf("vec_ovf d%0d v%0d", k, i),
                            int'(of[k]), int'(tbl[i].ovf));
                    end
                end
            end
        end

        // Reset while two results are in flight and the output is stalled.
        @(negedge clk);
        out_ready = 1'b0; a = 4'b0110; b = 7'b0010100; in_valid = 1'b1;
        @(negedge clk);
        a = 4'b0111; b = 7'b0111111;
        @(negedge clk);
        in_valid = 1'b0;
        chk(ov[0] === 1'b1, "pre_rst out_valid d0", int'(ov[0]), 1);
        chk(cc[0] === 7'd15, "pre_rst c d0", int'(cc[0]), 15);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk(ov[k] === 1'b0, $sformatf("midrst out_valid d%0d", k), int'(ov[k]), 0);
            chk(cc[k] === 7'd0, $sformatf("midrst c d%0d", k), int'(cc[k]), 0);
            chk(of[k] === 1'b0, $sformatf("midrst ovf d%0d", k), int'(of[k]), 0);
            chk(ir[k] === 1'b1, $sformatf("midrst in_ready d%0d", k), int'(ir[k]), 1);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                chk(ov[k] === 1'b0, $sformatf("post_rst stale d%0d c%0d", k, cyc), int'(ov[k]), 0);
        end

        // Random streaming with pseudo-random backpressure against the model.
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            wp[k] = 0; rp[k] = 0; prev_stall[k] = 1'b0;
        end
        sb_en = 1'b1;
        for (int n = 0; n < 72; n++) begin
            in_valid  = ($urandom_range(0, 9) != 0);
            a         = 4'($urandom);
            b         = 7'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && !all_empty(); t++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk(wp[k] == rp[k], $sformatf("drain d%0d", k), wp[k] - rp[k], 0);
            chk(wp[k] >= 8, $sformatf("traffic d%0d", k), wp[k], 8);
        end
        sb_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
